// File: rtl/button_ctrl_pkg.sv
// Shared definitions for the button-control path: debounce FSM encodings,
// the default debounce length and the bit layout of the system word.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_NUM_BUTTONS     = 4;
  localparam int DEFAULT_DATA_WIDTH      = 32;

  // System word layout: levels at the bottom, sticky press events right above.
  localparam int LEVEL_LSB = 0;

  function automatic int evt_lsb(input int num_buttons);
    return LEVEL_LSB + num_buttons;
  endfunction

endpackage

// File: rtl/button_debounce_cell.sv
// One button: 2-flop synchroniser, debounce FSM with stability counter,
// registered debounced level and one-cycle press pulse.
module button_debounce_cell
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_raw,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The sample that moves RELEASED/PRESSED into a WAIT state is the first stable
  // one, so the WAIT state accepts on the counter value holding one fewer sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             sync_p0;
  logic             sync_p1;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= 1'b1;
      sync_p1     <= 1'b1;
      state       <= ST_RELEASED;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter on the raw pin
      sync_p0     <= btn_n_raw;
      sync_p1     <= sync_p0;
      // stage p1 -> FSM: debounce on the synchronised level
      press_pulse <= 1'b0;
      unique case (state)
        ST_RELEASED: begin
          cnt <= '0;
          if (!sync_p1) state <= ST_PRESS_WAIT;
        end
        ST_PRESS_WAIT: begin
          if (sync_p1) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          cnt <= '0;
          if (sync_p1) state <= ST_RELEASE_WAIT;
        end
        ST_RELEASE_WAIT: begin
          if (!sync_p1) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign level = (state == ST_PRESSED) || (state == ST_RELEASE_WAIT);

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS active-low pins and packs levels plus sticky
// press-event bits into the system word read by the button register file.
module button_debouncer
  import button_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_n_raw,
  input  logic [NUM_BUTTONS-1:0] evt_clr,
  output logic [DATA_WIDTH-1:0]  data_system,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic                   evt_pending
);

  localparam int EVT_LSB = evt_lsb(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] evt;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
    button_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n_raw  (btn_n_raw[i]),
      .level      (level[i]),
      .press_pulse(press_pulse[i])
    );
  end

  // A press landing in the same cycle as a clear must not be lost, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~evt_clr) | press_pulse;
    end
  end

  always_comb begin
    data_system = '0;
    data_system[LEVEL_LSB +: NUM_BUTTONS] = level;
    data_system[EVT_LSB   +: NUM_BUTTONS] = evt;
  end

  assign evt_pending = |evt;

endmodule
